fabric_stream_fifo: RTL and testbench
=====================================

FABRIC_STREAM_FIFO -- requirements
Module: fabric_stream_fifo

Interface
REQ-001 Parameter WIDTH, default 32: payload bit width; SHALL be >= 1.
REQ-002 Parameter DEPTH, default 4: storage entries; SHALL be >= 1; non-power-of-2 values SHALL be supported.
REQ-003 Parameter BYPASS, default 0: 1 enables zero-latency pass-through when the FIFO is empty.
REQ-004 Parameter AF_LEVEL, default DEPTH-1: almost_full threshold; SHALL satisfy 1 <= AF_LEVEL <= DEPTH.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 in_valid  input  1  upstream offers in_data.
REQ-008 in_ready  output  1  FIFO accepts this cycle.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 out_valid  output  1  out_data is valid.
REQ-011 out_ready  input  1  downstream accepts.
REQ-012 out_data  output  WIDTH  head payload.
REQ-013 count  output  $clog2(DEPTH+1)  stored entries, registered.
REQ-014 almost_full  output  1  high when count >= AF_LEVEL, registered.

Function
REQ-015 Push SHALL occur iff in_valid && in_ready at a clock edge; pop SHALL occur iff out_valid && out_ready.
REQ-016 in_ready SHALL equal (count < DEPTH), independent of out_ready; a full FIFO SHALL NOT accept even if a pop occurs the same cycle.
REQ-017 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-018 Write and read pointers SHALL wrap from DEPTH-1 to 0.
REQ-019 BYPASS=0: out_valid SHALL equal (count != 0); out_data SHALL be the entry at the read pointer; push-to-out_valid latency SHALL be exactly 1 cycle.
REQ-020 BYPASS=1, count==0: out_valid SHALL equal in_valid and out_data SHALL equal in_data combinationally; if out_ready is also high the beat SHALL pass through without being stored and count SHALL stay 0.
REQ-021 BYPASS=1, count==0, in_valid && !out_ready: the beat SHALL be stored (count becomes 1).
REQ-022 BYPASS=1, count!=0: behaviour SHALL be identical to BYPASS=0 (order preserved, no bypass).
REQ-023 Order SHALL be strict FIFO; no beat SHALL be dropped or duplicated.
REQ-024 Once out_valid is high without out_ready, out_valid and out_data SHALL hold until pop (for BYPASS=1 with count==0 this relies on the upstream holding in_valid/in_data).
REQ-025 out_data is don't-care while out_valid is low.
REQ-026 count SHALL never exceed DEPTH; almost_full SHALL update on the same edge as count.
REQ-027 Under FABRIC_ASSERTIONS_ON: assert count <= DEPTH; assert out_valid/out_data stability per REQ-024; assert parameter legality at elaboration.

Reset
REQ-028 rst_n low SHALL immediately clear pointers and count to 0, drive out_valid 0, almost_full 0 (AF_LEVEL >= 1), in_ready 1 (BYPASS=1: out_valid follows in_valid per REQ-020).
REQ-029 Storage array SHALL NOT be reset; contents are discarded on reset.
REQ-030 Reset asserted mid-transfer SHALL discard all stored beats; the first beat after release SHALL be treated as into an empty FIFO.

Verification (WIDTH=8, DEPTH=3, AF_LEVEL=2 unless stated)
REQ-031 Fill: push 0x11,0x22,0x33 with out_ready=0 -> count 1,2,3; almost_full high after 2nd push; in_ready 0 after 3rd; 4th offer 0x44 not accepted.
REQ-032 Wrap: push/pop continuously 10 beats 0x00..0x09 with out_ready=1 -> output order 0x00..0x09, pointers wrap 2->0, count stays <= 1, first out_valid 1 cycle after first push.
REQ-033 Full+pop: at count=3, in_valid=1, out_ready=1 -> pop 0x11 only, count 2, no push that cycle; push accepted next cycle.
REQ-034 Bypass (BYPASS=1): empty, in_valid=1, in_data=0xA5, out_ready=1 -> out_valid=1, out_data=0xA5 same cycle, count remains 0; repeat with out_ready=0 -> count 1, 0xA5 held on out_data.
REQ-035 Reset mid-operation: count=2, assert rst_n low between edges -> count 0, out_valid 0, in_ready 1 without waiting for clk; after release push 0x5A -> out_data 0x5A next cycle.
REQ-036 Random back-pressure: 1000 beats, random in_valid/out_ready at 50% -> scoreboard match, no assertion failures, count never > 3.

Source files
------------

// File: rtl/fabric_stream_fifo.sv
// Valid/ready stream FIFO with arbitrary depth, registered occupancy flags
// and an optional zero-latency bypass path when empty.
module fabric_stream_fifo #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned BYPASS   = 0,
  parameter int unsigned AF_LEVEL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit          BYP = (BYPASS != 0);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, wr_ptr_d;
  logic [PW-1:0]    rd_ptr, rd_ptr_d;
  logic [CW-1:0]    count_d;
  logic             nonempty, nonempty_d;
  logic             in_ready_d, almost_full_d;
  logic             push, pop, bypass_hit, wr_en, rd_en;

  // Non-power-of-2 safe pointer increment.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshakes; a bypassed beat touches neither storage nor pointers.
  always_comb begin
    out_valid  = nonempty || (BYP && in_valid);
    out_data   = (BYP && !nonempty) ? in_data : mem[rd_ptr];
    push       = in_valid && in_ready;
    pop        = out_valid && out_ready;
    bypass_hit = BYP && !nonempty && in_valid && out_ready;
    wr_en      = push && !bypass_hit;
    rd_en      = pop && !bypass_hit;
  end

  // Next-state for pointers, occupancy and the registered flags.
  always_comb begin
    wr_ptr_d      = wr_ptr;
    rd_ptr_d      = rd_ptr;
    count_d       = count;
    if (wr_en) wr_ptr_d = ptr_inc(wr_ptr);
    if (rd_en) rd_ptr_d = ptr_inc(rd_ptr);
    if (wr_en && !rd_en) begin
      count_d = count + CW'(1);
    end else if (!wr_en && rd_en) begin
      count_d = count - CW'(1);
    end
    nonempty_d    = (count_d != '0);
    in_ready_d    = (count_d < CW'(DEPTH));
    almost_full_d = (count_d >= CW'(AF_LEVEL));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      nonempty    <= 1'b0;
      in_ready    <= 1'b1;
      almost_full <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_d;
      rd_ptr      <= rd_ptr_d;
      count       <= count_d;
      nonempty    <= nonempty_d;
      in_ready    <= in_ready_d;
      almost_full <= almost_full_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_data;
  end

`ifdef FABRIC_ASSERTIONS_ON
  if (WIDTH == 0 || DEPTH == 0 || AF_LEVEL == 0 || AF_LEVEL > DEPTH) begin : g_bad_params
    $fatal(1, "fabric_stream_fifo: illegal parameters");
  end

  a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
    count <= CW'(DEPTH));

  a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));
`endif

endmodule

// File: tb/tb_fabric_stream_fifo.sv
// Scoreboard bench: one buffered FIFO and one bypass FIFO (8b, depth 3, AF 2)
// checked every cycle against queue-based reference models.
module tb_fabric_stream_fifo;

  localparam int N = 1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid0, in_ready0, out_valid0, out_ready0, almost_full0;
  logic [7:0] in_data0, out_data0;
  logic [1:0] count0;
  logic       in_valid1, in_ready1, out_valid1, out_ready1, almost_full1;
  logic [7:0] in_data1, out_data1;
  logic [1:0] count1;

  int total = 0;
  int bad   = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  always #5 clk = ~clk;

  fabric_stream_fifo #(.WIDTH(8), .DEPTH(3), .BYPASS(0), .AF_LEVEL(2)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .count(count0), .almost_full(almost_full0)
  );

  fabric_stream_fifo #(.WIDTH(8), .DEPTH(3), .BYPASS(1), .AF_LEVEL(2)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .count(count1), .almost_full(almost_full1)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model for the buffered FIFO.
  always @(negedge clk) begin
    logic do_push, do_pop;
    logic [7:0] exp;
    if (!rst_n) begin
      q0.delete();
    end else begin
      check("count0", 32'(count0), 32'(q0.size()));
      check("almost_full0", 32'(almost_full0), 32'(q0.size() >= 2));
      check("in_ready0", 32'(in_ready0), 32'(q0.size() < 3));
      check("out_valid0", 32'(out_valid0), 32'(q0.size() != 0));
      do_pop  = out_ready0 && (q0.size() != 0);
      do_push = in_valid0 && (q0.size() < 3);
      if (do_push) q0.push_back(in_data0);
      if (do_pop) begin
        exp = q0.pop_front();
        check("out_data0", 32'(out_data0), 32'(exp));
      end
    end
  end

  // Reference model for the bypass FIFO: an empty queue forwards the offered beat.
  always @(negedge clk) begin
    logic do_push, do_pop;
    logic [7:0] exp;
    if (!rst_n) begin
      q1.delete();
    end else begin
      check("count1", 32'(count1), 32'(q1.size()));
      check("almost_full1", 32'(almost_full1), 32'(q1.size() >= 2));
      check("in_ready1", 32'(in_ready1), 32'(q1.size() < 3));
      check("out_valid1", 32'(out_valid1), 32'(q1.size() != 0 || in_valid1));
      do_pop  = out_ready1 && (q1.size() != 0 || in_valid1);
      do_push = in_valid1 && (q1.size() < 3);
      if (do_push) q1.push_back(in_data1);
      if (do_pop) begin
        exp = q1.pop_front();
        check("out_data1", 32'(out_data1), 32'(exp));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  sent0, sent1;
    logic acc0, acc1;
    rst_n = 1'b1;
    {in_valid0, out_ready0, in_valid1, out_ready1} = '0;
    in_data0 = '0;
    in_data1 = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_count0", 32'(count0), 0);
    check("rst_out_valid0", 32'(out_valid0), 0);
    check("rst_in_ready0", 32'(in_ready0), 1);
    check("rst_af0", 32'(almost_full0), 0);
    check("rst_out_valid1", 32'(out_valid1), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fill to full, then offer a fourth beat that must be refused.
    in_valid0 = 1'b1; in_data0 = 8'h11; cyc();
    check("fill_count_1", 32'(count0), 1);
    check("fill_af_1", 32'(almost_full0), 0);
    in_data0 = 8'h22; cyc();
    check("fill_af_2", 32'(almost_full0), 1);
    in_data0 = 8'h33; cyc();
    check("fill_count_3", 32'(count0), 3);
    check("fill_in_ready_3", 32'(in_ready0), 0);
    in_data0 = 8'h44; cyc();
    check("full_refuse", 32'(count0), 3);
    // Full with pop: only the pop happens; the held beat lands a cycle later.
    out_ready0 = 1'b1; cyc();
    check("fullpop_count", 32'(count0), 2);
    check("fullpop_in_ready", 32'(in_ready0), 1);
    out_ready0 = 1'b0; cyc();
    check("fullpop_push_next", 32'(count0), 3);
    in_valid0 = 1'b0; out_ready0 = 1'b1;
    repeat (3) cyc();
    check("drain_count", 32'(count0), 0);

    // Streaming through the pointer wrap.
    in_valid0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data0 = 8'(i);
      cyc();
      check("wrap_count", 32'(count0), 1);
    end
    in_valid0 = 1'b0;
    cyc();
    out_ready0 = 1'b0;
    check("wrap_drained", 32'(count0), 0);

    // Bypass: same-cycle pass-through, then a stalled beat that gets stored.
    in_valid1 = 1'b1; in_data1 = 8'hA5; out_ready1 = 1'b1;
    #1;
    check("byp_out_valid", 32'(out_valid1), 1);
    check("byp_out_data", 32'(out_data1), 32'h A5);
    @(posedge clk); #1;
    check("byp_count0", 32'(count1), 0);
    out_ready1 = 1'b0; cyc();
    check("byp_store_count", 32'(count1), 1);
    in_valid1 = 1'b0; in_data1 = 8'h00; cyc();
    check("byp_hold_valid", 32'(out_valid1), 1);
    check("byp_hold_data", 32'(out_data1), 32'h A5);
    out_ready1 = 1'b1; cyc();
    out_ready1 = 1'b0;
    check("byp_drained", 32'(count1), 0);

    // Asynchronous reset in the middle of a transfer.
    in_valid0 = 1'b1; in_data0 = 8'hA1; cyc();
    in_data0 = 8'hA2; cyc();
    in_valid0 = 1'b0;
    check("pre_reset_count", 32'(count0), 2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_count", 32'(count0), 0);
    check("async_rst_out_valid", 32'(out_valid0), 0);
    check("async_rst_in_ready", 32'(in_ready0), 1);
    check("async_rst_af", 32'(almost_full0), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    in_valid0 = 1'b1; in_data0 = 8'h5A; cyc();
    in_valid0 = 1'b0;
    check("post_rst_valid", 32'(out_valid0), 1);
    check("post_rst_data", 32'(out_data0), 32'h 5A);
    out_ready0 = 1'b1; cyc();
    out_ready0 = 1'b0;

    // Random traffic; upstream holds each offer until it is accepted.
    sent0 = 0;
    sent1 = 0;
    for (int c = 0; c < 20000; c++) begin
      if (sent0 == N && sent1 == N && !in_valid0 && !in_valid1 &&
          q0.size() == 0 && q1.size() == 0) break;
      @(negedge clk);
      acc0 = in_valid0 && in_ready0;
      acc1 = in_valid1 && in_ready1;
      @(posedge clk); #1;
      if (acc0) begin sent0++; in_valid0 = 1'b0; end
      if (acc1) begin sent1++; in_valid1 = 1'b0; end
      if (!in_valid0 && sent0 < N && $urandom_range(1) == 1) begin
        in_valid0 = 1'b1;
        in_data0  = 8'($urandom);
      end
      if (!in_valid1 && sent1 < N && $urandom_range(1) == 1) begin
        in_valid1 = 1'b1;
        in_data1  = 8'($urandom);
      end
      out_ready0 = 1'($urandom_range(1));
      out_ready1 = 1'($urandom_range(1));
    end
    out_ready0 = 1'b0;
    out_ready1 = 1'b0;
    cyc();
    check("rand_sent0", 32'(sent0), N);
    check("rand_sent1", 32'(sent1), N);
    check("rand_left0", 32'(q0.size()), 0);
    check("rand_left1", 32'(q1.size()), 0);
    check("rand_count0", 32'(count0), 0);
    check("rand_count1", 32'(count1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
